bcnn_maxpool2x2_bin: RTL and testbench
======================================

# bcnn_maxpool2x2_bin

Binary 2x2 max-pool stage that sits directly downstream of the 3x3 convolution + binarizer pair. It consumes the raster-ordered 1-bit feature map (26x26 for a 28x28 image), ORs each non-overlapping 2x2 window (binary max), and streams out the 13x13 pooled map with row/column coordinates. Line storage is one half-width bit row, so it needs no frame buffer.

## Interface

- `IN_WIDTH`, default 26: input feature-map columns.
- `IN_HEIGHT`, default 26: input feature-map rows.
- `OUT_WIDTH`, derived `IN_WIDTH/2` (floor), localparam: pooled columns.
- `OUT_HEIGHT`, derived `IN_HEIGHT/2` (floor), localparam: pooled rows.
- `CW`, derived `$clog2(OUT_WIDTH)` (min 1): output column index width.
- `RW`, derived `$clog2(OUT_HEIGHT)` (min 1): output row index width.

- `clk` input 1: single clock; all state on rising edge.
- `reset` input 1: synchronous, active-low. Sampled on `clk`; `reset`=0 resets.
- `bit_in` input 1: binarized feature pixel, raster order (row-major, col 0 first).
- `valid_in` input 1: `bit_in` valid this cycle. Gaps allowed.
- `pool_out` output 1: OR of the 2x2 window.
- `valid_out` output 1: one-cycle pulse per pooled pixel.
- `out_row` output RW: pooled row of `pool_out`.
- `out_col` output CW: pooled column of `pool_out`.
- `frame_done` output 1: one-cycle pulse with the final pooled pixel of a frame.

## Operation

- Counters `in_col` (0..IN_WIDTH-1) and `in_row` (0..IN_HEIGHT-1) advance only on `valid_in`=1. `in_col` wraps to 0 and increments `in_row` at IN_WIDTH-1. Both wrap to 0 after (IN_HEIGHT-1, IN_WIDTH-1); the next frame follows immediately with no idle cycle required.
- Horizontal pairing: at even `in_col`, store `bit_in` in `hold`. At odd `in_col`, `pair = hold | bit_in`.
- Vertical pairing:
  - Even `in_row`: write `pair` to `linebuf[in_col>>1]` (IN_WIDTH/2 bits).
  - Odd `in_row`: `result = linebuf[in_col>>1] | pair`. Register it to `pool_out` with `out_row=in_row>>1`, `out_col=in_col>>1`, and assert `valid_out`.
- Odd dimensions use floor semantics:
  - If IN_WIDTH is odd, the last column is consumed (counters advance) but never pooled.
  - If IN_HEIGHT is odd, the last row is consumed with no writes or outputs.
- `frame_done` is asserted together with `valid_out` for pooled pixel (OUT_HEIGHT-1, OUT_WIDTH-1).
- `linebuf` is not reset. Every entry is written on an even row before the odd row reads it, so its content after reset is don't-care.
- No backpressure. The downstream stage must accept one pooled pixel per `valid_out`.

## Timing

- Reset values: `pool_out`=0, `valid_out`=0, `out_row`=0, `out_col`=0, `frame_done`=0, counters=0, `hold`=0.
- Latency: `valid_out` rises exactly 1 cycle after the `valid_in` beat carrying the bottom-right pixel of the window (odd row, odd col).
- `valid_out` and `frame_done` are single-cycle pulses. They deassert on the next edge unless another completing beat occurs.
- Maximum rate is 1 pooled output per 2 input beats on odd rows; no outputs on even rows.
- Reset mid-frame: `reset`=0 takes priority over `valid_in` in the same cycle.
  - Counters return to (0,0); any pending output is dropped (`valid_out`=0 next cycle).
  - The next valid beat after release is treated as pixel (0,0) of a new frame.
- `valid_in`=0 cycles: all state holds and outputs pulse low; pooling is unaffected by gaps of any length.

## Test plan

- All-ones 26x26 frame, continuous `valid_in`: exactly 169 `valid_out` pulses, all `pool_out`=1. Coordinates sweep (0,0)..(12,12) in raster order. One `frame_done`, coincident with (12,12).
- All-zeros frame: 169 pulses, all `pool_out`=0. Then a single 1 at input (3,5): only output (1,2)=1, all others 0.
- Single 1 at input (2,0): only output (1,0)=1, which checks linebuf carry from the even row.
- Random frame with random `valid_in` gaps (~30% idle): the pooled map matches a reference OR-pool. Each `valid_out` comes exactly 1 cycle after its window's completing beat.
- `IN_WIDTH`=`IN_HEIGHT`=5, all-ones input: 4 outputs at (0,0),(0,1),(1,0),(1,1). Column 4 and row 4 produce nothing, and counters wrap after 25 beats.
- Assert `reset`=0 for 1 cycle at input (7,10) of a frame, then send a full all-ones frame: outputs resume at (0,0), 169 pulses, no stale output. Two back-to-back frames produce two `frame_done` pulses 676 valid beats apart.

Source files
------------

// File: rtl/bcnn_maxpool2x2_bin.sv
// Binary 2x2 max-pool: ORs each non-overlapping 2x2 window of a raster-ordered
// 1-bit feature map, using one half-width bit row as line storage.
module bcnn_maxpool2x2_bin #(
  parameter int IN_WIDTH  = 26,
  parameter int IN_HEIGHT = 26,
  localparam int OUT_WIDTH  = IN_WIDTH / 2,
  localparam int OUT_HEIGHT = IN_HEIGHT / 2,
  localparam int CW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1,
  localparam int RW = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bit_in,
  input  logic          valid_in,
  output logic          pool_out,
  output logic          valid_out,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          frame_done
);

  localparam int ICW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int IRW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;

  localparam logic [ICW-1:0] LAST_COL  = ICW'(IN_WIDTH - 1);
  localparam logic [IRW-1:0] LAST_ROW  = IRW'(IN_HEIGHT - 1);
  localparam logic [CW-1:0]  LAST_OCOL = CW'(OUT_WIDTH - 1);
  localparam logic [RW-1:0]  LAST_OROW = RW'(OUT_HEIGHT - 1);

  logic [ICW-1:0]       in_col;
  logic [IRW-1:0]       in_row;
  logic                 hold;
  logic [OUT_WIDTH-1:0] linebuf;

  logic          last_col;
  logic          last_row;
  logic          row_pooled;
  logic          pair;
  logic [CW-1:0] pair_idx;
  logic [RW-1:0] row_idx;
  logic          is_last_out;

  // An odd trailing column is always even-indexed, so it never completes a pair;
  // only an odd trailing row needs explicit exclusion from linebuf writes.
  assign last_col    = (in_col == LAST_COL);
  assign last_row    = (in_row == LAST_ROW);
  assign row_pooled  = !((IN_HEIGHT % 2 == 1) && last_row);
  assign pair        = hold | bit_in;
  assign pair_idx    = CW'(in_col >> 1);
  assign row_idx     = RW'(in_row >> 1);
  assign is_last_out = (pair_idx == LAST_OCOL) && (row_idx == LAST_OROW);

  always_ff @(posedge clk) begin
    if (reset && valid_in && !in_row[0] && in_col[0] && row_pooled)
      linebuf[pair_idx] <= pair;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      in_col     <= '0;
      in_row     <= '0;
      hold       <= 1'b0;
      pool_out   <= 1'b0;
      valid_out  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (last_col) begin
          in_col <= '0;
          in_row <= last_row ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end

        if (!in_col[0]) begin
          hold <= bit_in;
        end else if (in_row[0]) begin
          pool_out   <= linebuf[pair_idx] | pair;
          out_row    <= row_idx;
          out_col    <= pair_idx;
          valid_out  <= 1'b1;
          frame_done <= is_last_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcnn_maxpool2x2_bin.sv
// Scoreboard bench for bcnn_maxpool2x2_bin: 26x26 and 5x5 instances, directed
// frames plus a random gapped frame checked against a reference OR-pool.
module tb_bcnn_maxpool2x2_bin;

  typedef struct {
    logic   pool;
    int     row;
    int     col;
    logic   fd;
    longint cyc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       bit_in;
  logic       valid_in;
  logic       pool_out;
  logic       valid_out;
  logic [3:0] out_row;
  logic [3:0] out_col;
  logic       frame_done;

  logic       s_reset;
  logic       s_bit;
  logic       s_valid;
  logic       s_pool;
  logic       s_vout;
  logic [0:0] s_row;
  logic [0:0] s_col;
  logic       s_fd;

  bcnn_maxpool2x2_bin dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .valid_in(valid_in),
    .pool_out(pool_out), .valid_out(valid_out), .out_row(out_row),
    .out_col(out_col), .frame_done(frame_done)
  );

  bcnn_maxpool2x2_bin #(.IN_WIDTH(5), .IN_HEIGHT(5)) dut_s (
    .clk(clk), .reset(s_reset), .bit_in(s_bit), .valid_in(s_valid),
    .pool_out(s_pool), .valid_out(s_vout), .out_row(s_row),
    .out_col(s_col), .frame_done(s_fd)
  );

  exp_t   q[$];
  exp_t   sq[$];
  bit     img [0:25][0:25];
  bit     simg [0:4][0:4];
  longint cyc = 0;
  int     checks = 0;
  int     fails = 0;
  int     pulses = 0, ones = 0, fd_count = 0;
  longint fd_last = 0, fd_prev = 0;
  int     s_pulses = 0, s_fd_count = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Main-instance monitor: every valid_out pops the oldest expectation.
  always @(negedge clk) begin
    if (valid_out) begin
      pulses++;
      if (pool_out) ones++;
      if (q.size() == 0) begin
        check_output("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check_output("pool_out", pool_out, e.pool);
        check_output("out_row", out_row, e.row);
        check_output("out_col", out_col, e.col);
        check_output("frame_done", frame_done, e.fd);
        check_output("latency_cycle", cyc, e.cyc);
      end
    end else if (frame_done) begin
      check_output("frame_done_alone", frame_done, 1'b0);
    end
    if (frame_done) begin
      fd_count++;
      fd_prev = fd_last;
      fd_last = cyc;
    end
  end

  // Small-instance monitor.
  always @(negedge clk) begin
    if (s_vout) begin
      s_pulses++;
      if (sq.size() == 0) begin
        check_output("s_unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sq.pop_front();
        check_output("s_pool_out", s_pool, e.pool);
        check_output("s_out_row", s_row, e.row);
        check_output("s_out_col", s_col, e.col);
        check_output("s_frame_done", s_fd, e.fd);
        check_output("s_latency_cycle", cyc, e.cyc);
      end
    end
    if (s_fd) s_fd_count++;
  end

  // Sends beats 0..stop_at-1 of img, idle_pct percent random gap cycles.
  task automatic apply_stimulus(input int idle_pct, input int stop_at);
    for (int r = 0; r < 26; r++) begin
      for (int c = 0; c < 26; c++) begin
        if (r * 26 + c < stop_at) begin
          while ($urandom_range(0, 99) < idle_pct) begin
            @(negedge clk);
            valid_in = 1'b0;
            bit_in   = 1'($urandom_range(0, 1));
          end
          @(negedge clk);
          valid_in = 1'b1;
          bit_in   = img[r][c];
          if ((r % 2 == 1) && (c % 2 == 1)) begin
            exp_t e;
            e.pool = img[r-1][c-1] | img[r-1][c] | img[r][c-1] | img[r][c];
            e.row  = r / 2;
            e.col  = c / 2;
            e.fd   = (r == 25) && (c == 25);
            e.cyc  = cyc + 1;
            q.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic apply_small_frame();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        s_valid = 1'b1;
        s_bit   = simg[r][c];
        if ((r % 2 == 1) && (c % 2 == 1) && r < 4 && c < 4) begin
          exp_t e;
          e.pool = simg[r-1][c-1] | simg[r-1][c] | simg[r][c-1] | simg[r][c];
          e.row  = r / 2;
          e.col  = c / 2;
          e.fd   = (r == 3) && (c == 3);
          e.cyc  = cyc + 1;
          sq.push_back(e);
        end
      end
    end
  endtask

  task automatic go_idle_and_drain();
    @(negedge clk);
    valid_in = 1'b0;
    s_valid  = 1'b0;
    for (int i = 0; i < 8 && (q.size() != 0 || sq.size() != 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check_output("queue_drained", q.size(), 0);
    check_output("s_queue_drained", sq.size(), 0);
  endtask

  task automatic fill_img(input int mode);
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 26; c++)
        img[r][c] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  initial begin
    int p0, o0, f0;
    reset = 1'b0; valid_in = 1'b0; bit_in = 1'b0;
    s_reset = 1'b0; s_valid = 1'b0; s_bit = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_pool_out", pool_out, 0);
    check_output("rst_valid_out", valid_out, 0);
    check_output("rst_out_row", out_row, 0);
    check_output("rst_out_col", out_col, 0);
    check_output("rst_frame_done", frame_done, 0);
    check_output("s_rst_valid_out", s_vout, 0);
    reset = 1'b1; s_reset = 1'b1;
    @(negedge clk);

    $display("[TB] all-ones frame");
    fill_img(1);
    p0 = pulses; o0 = ones; f0 = fd_count;
    apply_stimulus(0, 676);
    go_idle_and_drain();
    check_output("ones_pulses", pulses - p0, 169);
    check_output("ones_count", ones - o0, 169);
    check_output("ones_frame_done", fd_count - f0, 1);

    $display("[TB] all-zeros frame");
    fill_img(0);
    p0 = pulses; o0 = ones;
    apply_stimulus(0, 676);
    go_idle_and_drain();
    check_output("zeros_pulses", pulses - p0, 169);
    check_output("zeros_count", ones - o0, 0);

    $display("[TB] single one at (3,5)");
    fill_img(0);
    img[3][5] = 1'b1;
    o0 = ones;
    apply_stimulus(0, 676);
    go_idle_and_drain();
    check_output("single35_ones", ones - o0, 1);

    $display("[TB] single one at (2,0)");
    fill_img(0);
    img[2][0] = 1'b1;
    o0 = ones;
    apply_stimulus(0, 676);
    go_idle_and_drain();
    check_output("single20_ones", ones - o0, 1);

    $display("[TB] random frame with gaps");
    fill_img(2);
    p0 = pulses;
    apply_stimulus(30, 676);
    go_idle_and_drain();
    check_output("random_pulses", pulses - p0, 169);

    $display("[TB] reset mid-frame then two back-to-back frames");
    fill_img(1);
    apply_stimulus(0, 7 * 26 + 10);
    @(negedge clk);
    reset = 1'b0; valid_in = 1'b1; bit_in = 1'b1;
    @(negedge clk);
    check_output("midrst_valid_out", valid_out, 0);
    check_output("midrst_out_row", out_row, 0);
    check_output("midrst_out_col", out_col, 0);
    reset = 1'b1; valid_in = 1'b0;
    check_output("midrst_queue_empty", q.size(), 0);
    p0 = pulses; f0 = fd_count;
    apply_stimulus(0, 676);
    apply_stimulus(0, 676);
    go_idle_and_drain();
    check_output("b2b_pulses", pulses - p0, 338);
    check_output("b2b_frame_done", fd_count - f0, 2);
    check_output("b2b_fd_spacing", fd_last - fd_prev, 676);

    $display("[TB] 5x5 instance");
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) simg[r][c] = 1'b1;
    apply_small_frame();
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) simg[r][c] = 1'b0;
    simg[0][0] = 1'b1;
    apply_small_frame();
    go_idle_and_drain();
    check_output("s_pulses", s_pulses, 8);
    check_output("s_frame_done", s_fd_count, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
